// File: rtl/debug_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : debug_unit
//  Description : Host-side debug controller for the MIPS pipeline. Decodes
//                single-byte UART commands (step / run / dump), gates the
//                pipeline clock enable and serialises a fixed-format state
//                dump (PC, ALU result, registers, data memory) MSB byte first.
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_unit #(
  parameter int NB              = 32,
  parameter int N_REGS          = 32,
  parameter int TAM_DATA_MEMORY = 16,
  parameter int NB_BYTE         = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_ready,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_step,
  output logic [4:0]         o_debug_mips_register_number,
  output logic [NB-1:0]      o_debug_address,
  input  logic [NB-1:0]      i_mips_pc,
  input  logic [NB-1:0]      i_mips_alu_result,
  input  logic [NB-1:0]      i_mips_register_data,
  input  logic [NB-1:0]      i_mips_data_memory,
  input  logic               i_mips_halt,
  output logic               o_busy
);

  // Frame geometry: PC, ALU result, every register, then the data memory.
  localparam int N_WORDS = 2 + N_REGS + TAM_DATA_MEMORY;
  localparam int W_W     = $clog2(N_WORDS);
  localparam int N_BYTES = NB / NB_BYTE;
  localparam int BC_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  localparam logic [W_W-1:0]     LAST_WORD = W_W'(N_WORDS - 1);
  localparam logic [W_W-1:0]     ALU_WORD  = W_W'(1);
  localparam logic [W_W-1:0]     REG_FIRST = W_W'(2);
  localparam logic [W_W-1:0]     MEM_FIRST = W_W'(2 + N_REGS);
  localparam logic [BC_W-1:0]    LAST_BYTE = BC_W'(N_BYTES - 1);

  localparam logic [NB_BYTE-1:0] CMD_STEP  = NB_BYTE'(8'h73);
  localparam logic [NB_BYTE-1:0] CMD_RUN   = NB_BYTE'(8'h63);
  localparam logic [NB_BYTE-1:0] CMD_DUMP  = NB_BYTE'(8'h64);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_STEP        = 3'd1,
    S_RUN         = 3'd2,
    S_SELECT      = 3'd3,
    S_CAPTURE     = 3'd4,
    S_SEND        = 3'd5,
    S_WAIT_ACCEPT = 3'd6
  } state_t;

  state_t               state_q;
  logic [W_W-1:0]       word_idx_q;
  logic [BC_W-1:0]      byte_cnt_q;
  logic [NB-1:0]        shift_q;
  logic [NB_BYTE-1:0]   tx_data_q;
  logic                 tx_start_q;
  logic                 step_q;
  logic [4:0]           reg_num_q;
  logic [NB-1:0]        addr_q;
  logic                 busy_q;

  logic [W_W-1:0]       reg_idx;
  logic [W_W-1:0]       mem_idx;
  logic [NB-1:0]        word_d;

  assign reg_idx = word_idx_q - REG_FIRST;
  assign mem_idx = word_idx_q - MEM_FIRST;

  // Pick the pipeline value that belongs to the current dump word.
  always_comb begin
    word_d = i_mips_data_memory;
    if (word_idx_q == '0) begin
      word_d = i_mips_pc;
    end else if (word_idx_q == ALU_WORD) begin
      word_d = i_mips_alu_result;
    end else if (word_idx_q < MEM_FIRST) begin
      word_d = i_mips_register_data;
    end
  end

  // Command decode, step/run gating and dump serialiser with registered outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      step_q     <= 1'b0;
      reg_num_q  <= '0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_rx_valid) begin
            if (i_rx_data == CMD_STEP) begin
              state_q <= S_STEP;
              step_q  <= 1'b1;
              busy_q  <= 1'b1;
            end else if (i_rx_data == CMD_RUN) begin
              state_q <= S_RUN;
              step_q  <= 1'b1;
              busy_q  <= 1'b1;
            end else if (i_rx_data == CMD_DUMP) begin
              state_q    <= S_SELECT;
              word_idx_q <= '0;
              busy_q     <= 1'b1;
            end
          end
        end
        S_STEP: begin
          // Single pipeline advance, then dump the resulting state.
          step_q     <= 1'b0;
          word_idx_q <= '0;
          state_q    <= S_SELECT;
        end
        S_RUN: begin
          if (i_mips_halt) begin
            step_q     <= 1'b0;
            word_idx_q <= '0;
            state_q    <= S_SELECT;
          end
        end
        S_SELECT: begin
          // PC and ALU words need no select; leave the read ports untouched.
          if (word_idx_q >= MEM_FIRST) begin
            addr_q <= NB'(mem_idx) << 2;
          end else if (word_idx_q >= REG_FIRST) begin
            reg_num_q <= 5'(reg_idx);
          end
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // Read data has had a full cycle to settle after the select change.
          shift_q    <= word_d;
          byte_cnt_q <= '0;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (i_tx_ready) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= shift_q[NB-1 -: NB_BYTE];
            state_q    <= S_WAIT_ACCEPT;
          end
        end
        S_WAIT_ACCEPT: begin
          // Ready dropping is the transmitter's acknowledgement of the byte.
          if (!i_tx_ready) begin
            if (byte_cnt_q != LAST_BYTE) begin
              shift_q    <= shift_q << NB_BYTE;
              byte_cnt_q <= byte_cnt_q + 1'b1;
              state_q    <= S_SEND;
            end else if (word_idx_q != LAST_WORD) begin
              word_idx_q <= word_idx_q + 1'b1;
              state_q    <= S_SELECT;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          step_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx_data                    = tx_data_q;
  assign o_tx_start                   = tx_start_q;
  assign o_step                       = step_q;
  assign o_debug_mips_register_number = reg_num_q;
  assign o_debug_address              = addr_q;
  assign o_busy                       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_debug_unit
//  Description : Directed self-checking bench for debug_unit with a small
//                pipeline model and a UART transmitter model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        step;
  logic [4:0]  reg_num;
  logic [31:0] dbg_addr;
  logic [31:0] pc, alu, reg_data, mem_data;
  logic        halt;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Pipeline model: each enabled cycle advances PC by 4 and executes ADDI $2,$2,1.
  logic [31:0] m_pc, m_r2;
  logic [31:0] halt_pc = 32'h0;
  logic        halt_en = 1'b0;
  logic        m_clr = 1'b1;
  logic        mon_clr = 1'b1;

  // Transmitter model and frame capture.
  int          busy_cnt = 0;
  logic [7:0]  frame [0:255];
  int          nb = 0;
  int          step_cnt = 0;

  always #5 clk = ~clk;

  debug_unit #(.NB(32), .N_REGS(32), .TAM_DATA_MEMORY(16), .NB_BYTE(8)) dut (
    .i_clk                        (clk),
    .i_reset                      (rst_n),
    .i_rx_data                    (rx_data),
    .i_rx_valid                   (rx_valid),
    .i_tx_ready                   (tx_ready),
    .o_tx_data                    (tx_data),
    .o_tx_start                   (tx_start),
    .o_step                       (step),
    .o_debug_mips_register_number (reg_num),
    .o_debug_address              (dbg_addr),
    .i_mips_pc                    (pc),
    .i_mips_alu_result            (alu),
    .i_mips_register_data         (reg_data),
    .i_mips_data_memory           (mem_data),
    .i_mips_halt                  (halt),
    .o_busy                       (busy)
  );

  always @(posedge clk) begin
    if (m_clr) begin
      m_pc <= 32'h0;
      m_r2 <= 32'h0;
    end else if (step) begin
      m_pc <= m_pc + 32'd4;
      m_r2 <= m_r2 + 32'd1;
    end
  end

  assign pc       = m_pc;
  assign alu      = m_pc ^ 32'h0000_FFFF;
  assign reg_data = (reg_num == 5'd7) ? 32'h5 :
                    (reg_num == 5'd2) ? m_r2 : (32'h1000_0000 | {27'h0, reg_num});
  assign mem_data = (dbg_addr[31:2] == 30'd4) ? 32'hDEAD_BEEF : (32'hC000_0000 | dbg_addr);
  assign halt     = halt_en && (m_pc >= halt_pc);
  assign tx_ready = (busy_cnt == 0);

  always @(posedge clk) begin
    if (tx_start) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (mon_clr) begin
      nb       <= 0;
      step_cnt <= 0;
    end else begin
      if (tx_start) begin
        if (nb < 256) frame[nb] <= tx_data;
        nb <= nb + 1;
      end
      if (step) step_cnt <= step_cnt + 1;
    end
  end

  function automatic logic [31:0] fword(input int w);
    return {frame[4*w], frame[4*w+1], frame[4*w+2], frame[4*w+3]};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic clear_all();
    @(negedge clk);
    m_clr   = 1'b1;
    mon_clr = 1'b1;
    @(negedge clk);
    m_clr   = 1'b0;
    mon_clr = 1'b0;
  endtask

  task automatic clear_mon();
    @(negedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_data, tx_start, step, reg_num, dbg_addr, busy} !== 47'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {tx_data, tx_start, step, reg_num, dbg_addr, busy});
    end
    rst_n   = 1'b1;
    m_clr   = 1'b0;
    mon_clr = 1'b0;
    send_byte(8'h41);
    repeat (20) @(negedge clk);
    checks++;
    if (step_cnt !== 0 || nb !== 0) begin
      errors++;
      $display("FAIL ignore_0x41: steps=%0d bytes=%0d required 0/0", step_cnt, nb);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_0x41_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_dump();
    clear_all();
    send_byte(8'h64);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL dump_busy: got %b required 1", busy);
    end
    wait_idle("dump_done");
    checks++;
    if (nb !== 200 || step_cnt !== 0) begin
      errors++;
      $display("FAIL dump_len: bytes=%0d steps=%0d required 200/0", nb, step_cnt);
    end
    checks++;
    if (fword(0) !== 32'h0 || fword(1) !== 32'h0000_FFFF) begin
      errors++;
      $display("FAIL dump_pc_alu: got %h %h required 00000000 0000ffff", fword(0), fword(1));
    end
    checks++;
    if (fword(9) !== 32'h0000_0005) begin
      errors++;
      $display("FAIL dump_reg7: got %h required 00000005", fword(9));
    end
    checks++;
    if (fword(38) !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL dump_mem4: got %h required deadbeef", fword(38));
    end
    checks++;
    if (fword(33) !== 32'h1000_001F || fword(49) !== 32'hC000_003C) begin
      errors++;
      $display("FAIL dump_last: got %h %h required 1000001f c000003c", fword(33), fword(49));
    end
    checks++;
    if (reg_num !== 5'd31 || dbg_addr !== 32'd60) begin
      errors++;
      $display("FAIL dump_hold_sel: got %0d %0d required 31 60", reg_num, dbg_addr);
    end
  endtask

  task automatic test_step();
    clear_all();
    send_byte(8'h73);
    wait_idle("step1_done");
    checks++;
    if (step_cnt !== 1 || nb !== 200 || fword(0) !== 32'h4) begin
      errors++;
      $display("FAIL step1: steps=%0d bytes=%0d pc=%h required 1/200/00000004", step_cnt, nb, fword(0));
    end
    clear_mon();
    send_byte(8'h73);
    wait_idle("step2_done");
    checks++;
    if (step_cnt !== 1 || fword(0) !== 32'h8 || fword(4) !== 32'h2) begin
      errors++;
      $display("FAIL step2: steps=%0d pc=%h r2=%h required 1/00000008/00000002", step_cnt, fword(0), fword(4));
    end
  endtask

  task automatic test_run();
    clear_all();
    halt_pc = 32'h20;
    halt_en = 1'b1;
    send_byte(8'h63);
    wait_idle("run_done");
    checks++;
    if (step_cnt !== 9 || fword(0) !== 32'h24 || fword(4) !== 32'h9) begin
      errors++;
      $display("FAIL run_halt: steps=%0d pc=%h r2=%h required 9/00000024/00000009", step_cnt, fword(0), fword(4));
    end
    checks++;
    if (fword(1) !== 32'h0000_FFDB || nb !== 200) begin
      errors++;
      $display("FAIL run_alu: alu=%h bytes=%0d required 0000ffdb/200", fword(1), nb);
    end
    // Halt already asserted when the run starts.
    halt_en = 1'b0;
    clear_all();
    halt_pc = 32'h0;
    halt_en = 1'b1;
    send_byte(8'h63);
    wait_idle("run_entry_halt_done");
    checks++;
    if (step_cnt !== 1 || fword(0) !== 32'h4) begin
      errors++;
      $display("FAIL run_entry_halt: steps=%0d pc=%h required 1/00000004", step_cnt, fword(0));
    end
    halt_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    clear_all();
    send_byte(8'h64);
    repeat (30) @(negedge clk);
    send_byte(8'h73);
    repeat (40) @(negedge clk);
    send_byte(8'h63);
    wait_idle("inject_done");
    repeat (5) @(negedge clk);
    checks++;
    if (nb !== 200 || step_cnt !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL inject: bytes=%0d steps=%0d busy=%b required 200/0/0", nb, step_cnt, busy);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    int snap;
    clear_all();
    send_byte(8'h64);
    while (nb < 50 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (nb < 50) begin
      errors++;
      $display("FAIL middump_reach: bytes=%0d required >=50", nb);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_data, tx_start, step, reg_num, dbg_addr, busy} !== 47'h0) begin
      errors++;
      $display("FAIL middump_reset: got %h required 0", {tx_data, tx_start, step, reg_num, dbg_addr, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    snap = nb;
    repeat (30) @(negedge clk);
    checks++;
    if (nb !== snap || busy !== 1'b0) begin
      errors++;
      $display("FAIL middump_idle: bytes=%0d busy=%b required %0d/0", nb, busy, snap);
    end
    // Abort a run in progress.
    clear_all();
    send_byte(8'h63);
    repeat (5) @(negedge clk);
    checks++;
    if (step !== 1'b1) begin
      errors++;
      $display("FAIL midrun_step: got %b required 1", step);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (step !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: step=%b busy=%b required 0/0", step, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    snap = step_cnt;
    repeat (10) @(negedge clk);
    checks++;
    if (step_cnt !== snap || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_idle: steps=%0d busy=%b required %0d/0", step_cnt, busy, snap);
    end
    clear_all();
    send_byte(8'h64);
    wait_idle("redump_done");
    checks++;
    if (nb !== 200 || fword(0) !== 32'h0 || fword(38) !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL redump: bytes=%0d pc=%h mem4=%h required 200/00000000/deadbeef", nb, fword(0), fword(38));
    end
  endtask

  initial begin
    test_reset();
    test_dump();
    test_step();
    test_run();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
